// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FP issue controller: controller state encoding,
// FP opcode width and FP opcode constants.
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int FP_OPW = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_WB     = 2'd3
    } fpu_state_e;

    localparam logic [FP_OPW-1:0] FP_OP_ADD  = 3'd0;
    localparam logic [FP_OPW-1:0] FP_OP_SUB  = 3'd1;
    localparam logic [FP_OPW-1:0] FP_OP_MUL  = 3'd2;
    localparam logic [FP_OPW-1:0] FP_OP_DIV  = 3'd3;
    localparam logic [FP_OPW-1:0] FP_OP_SQRT = 3'd4;
    localparam logic [FP_OPW-1:0] FP_OP_CVT  = 3'd5;
    localparam logic [FP_OPW-1:0] FP_OP_MIN  = 3'd6;
    localparam logic [FP_OPW-1:0] FP_OP_MAX  = 3'd7;

endpackage

// File: rtl/fpu_timeout_ctr.sv
// -----------------------------------------------------------------------------
// fpu_timeout_ctr
// Counts cycles spent waiting for the FPU.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clear   : zero the count (asserted the cycle before waiting starts)
//   enable  : one waiting cycle elapses this cycle
//   expired : the count including the current cycle has reached TIMEOUT
// -----------------------------------------------------------------------------
module fpu_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    // Comparing the incremented value means the TIMEOUT-th waiting cycle is
    // the last one: the controller leaves WAIT after exactly TIMEOUT cycles.
    // The count never exceeds TIMEOUT, which fits in CW bits.
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        expired = enable && (cnt_inc >= LIMIT);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_inc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
// Issues one FP instruction at a time to a multi-cycle FPU, stalls the core
// while it runs, writes the result back to the FP register file and keeps
// sticky exception / timeout status.
//   clk, rst                  : clock, synchronous active-high reset
//   issue_valid/op/rd         : decoded FP instruction from the core
//   stall                     : hold PC and register writes
//   fpu_start, fpu_op         : launch pulse and held opcode to the FPU
//   fpu_done/result/exc       : FPU completion pulse, result, exception flags
//   fp_we, fp_wn, fp_wd       : FP register-file write port
//   exc_sticky, exc_clr       : accumulated exception flags and their clear
//   timeout_err               : last operation was aborted by timeout
// -----------------------------------------------------------------------------
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int OPW     = FP_OPW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issue_valid,
    input  logic [OPW-1:0] issue_op,
    input  logic [4:0]     issue_rd,
    output logic           stall,
    output logic           fpu_start,
    output logic [OPW-1:0] fpu_op,
    input  logic           fpu_done,
    input  logic [31:0]    fpu_result,
    input  logic [4:0]     fpu_exc,
    output logic           fp_we,
    output logic [4:0]     fp_wn,
    output logic [31:0]    fp_wd,
    output logic [4:0]     exc_sticky,
    input  logic           exc_clr,
    output logic           timeout_err
);

    fpu_state_e     state_q,  state_d;
    logic [OPW-1:0] op_q,     op_d;
    logic [4:0]     rd_q,     rd_d;
    logic [31:0]    result_q, result_d;
    logic [4:0]     exc_q,    exc_d;
    logic           terr_q,   terr_d;

    logic done_acc;
    logic ctr_expired;

    fpu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == ST_LAUNCH),
        .enable  (state_q == ST_WAIT),
        .expired (ctr_expired)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        result_d = result_q;
        terr_d   = terr_q;
        done_acc = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    op_d    = issue_op;
                    rd_d    = issue_rd;
                    terr_d  = 1'b0;   // reads 0 for the whole LAUNCH cycle
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                // A done in the final waiting cycle beats the timeout.
                if (fpu_done) begin
                    done_acc = 1'b1;
                    result_d = fpu_result;
                    state_d  = ST_WB;
                end else if (ctr_expired) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Clear first, then merge the new flags, so a coincident clear keeps
        // only the flags of the completing operation.
        exc_d = (exc_clr ? 5'b0 : exc_q) | (done_acc ? fpu_exc : 5'b0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            exc_q    <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            terr_q   <= terr_d;
        end
    end

    // While rst is high the state register may still hold a pre-reset value,
    // so the pulses are masked and stall behaves as if the state were IDLE.
    always_comb begin
        fpu_start = !rst && (state_q == ST_LAUNCH);
        fp_we     = !rst && (state_q == ST_WB);
        if (rst) begin
            stall = issue_valid;
        end else begin
            stall = ((state_q == ST_IDLE) && issue_valid) ||
                    (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
        end
    end

    assign fpu_op      = op_q;
    assign fp_wn       = rd_q;
    assign fp_wd       = result_q;
    assign exc_sticky  = exc_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_ctrl
// Directed stimulus for fpu_issue_ctrl. A transaction-level model tracks
// whether an operation is in flight and how many cycles it has aged; a compare
// process checks every DUT output against it each cycle, and the stimulus
// pins key cycles with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int OPW     = FP_OPW;

    logic           clk = 1'b0;
    logic           rst;
    logic           issue_valid;
    logic [OPW-1:0] issue_op;
    logic [4:0]     issue_rd;
    logic           stall;
    logic           fpu_start;
    logic [OPW-1:0] fpu_op;
    logic           fpu_done;
    logic [31:0]    fpu_result;
    logic [4:0]     fpu_exc;
    logic           fp_we;
    logic [4:0]     fp_wn;
    logic [31:0]    fp_wd;
    logic [4:0]     exc_sticky;
    logic           exc_clr;
    logic           timeout_err;

    fpu_issue_ctrl #(
        .TIMEOUT (TIMEOUT),
        .OPW     (OPW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .stall       (stall),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .fpu_done    (fpu_done),
        .fpu_result  (fpu_result),
        .fpu_exc     (fpu_exc),
        .fp_we       (fp_we),
        .fp_wn       (fp_wn),
        .fp_wd       (fp_wd),
        .exc_sticky  (exc_sticky),
        .exc_clr     (exc_clr),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // busy: an operation has been accepted and has not yet finished.
    // age : 1 in the launch cycle, 1+k in the k-th waiting cycle.
    // wb  : the result is being written this cycle.
    bit             model_on = 1'b0;
    bit             m_busy = 1'b0;
    bit             m_wb = 1'b0;
    int             m_age = 0;
    logic [OPW-1:0] m_op = '0;
    logic [4:0]     m_rd = '0;
    logic [31:0]    m_res = '0;
    logic [4:0]     m_exc = '0;
    bit             m_terr = 1'b0;

    always @(negedge clk) begin
        if (model_on) begin
            bit e_start, e_we, e_stall, acc;
            e_start = !rst && m_busy && !m_wb && (m_age == 1);
            e_we    = !rst && m_busy && m_wb;
            if (rst || !m_busy) e_stall = issue_valid;
            else                e_stall = !m_wb;

            check("m_stall",     32'(stall),       32'(e_stall));
            check("m_fpu_start", 32'(fpu_start),   32'(e_start));
            check("m_fp_we",     32'(fp_we),       32'(e_we));
            check("m_fpu_op",    32'(fpu_op),      32'(m_op));
            check("m_exc",       32'(exc_sticky),  32'(m_exc));
            check("m_terr",      32'(timeout_err), 32'(m_terr));
            if (e_we) begin
                check("m_fp_wn", 32'(fp_wn), 32'(m_rd));
                check("m_fp_wd", fp_wd, m_res);
            end

            // Advance to the state after this clock edge.
            acc = 1'b0;
            if (rst) begin
                m_busy = 0; m_wb = 0; m_age = 0; m_op = '0; m_rd = '0;
                m_res = '0; m_exc = '0; m_terr = 0;
            end else begin
                if (!m_busy) begin
                    if (issue_valid) begin
                        m_busy = 1; m_age = 1; m_op = issue_op; m_rd = issue_rd; m_terr = 0;
                    end
                end else if (m_wb) begin
                    m_busy = 0; m_wb = 0;
                end else if (m_age == 1) begin
                    m_age = 2;
                end else if (fpu_done) begin
                    acc = 1'b1; m_res = fpu_result; m_wb = 1;
                end else if (m_age - 1 == TIMEOUT) begin
                    m_busy = 0; m_terr = 1;
                end else begin
                    m_age++;
                end
                m_exc = (exc_clr ? 5'b0 : m_exc) | (acc ? fpu_exc : 5'b0);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    // Drive one cycle's inputs just after the rising edge, return at the
    // falling edge so the caller can sample outputs mid-cycle.
    task automatic drv(input logic iv, input logic [OPW-1:0] op, input logic [4:0] rd,
                       input logic dn, input logic [31:0] res, input logic [4:0] ex,
                       input logic clr, input logic r);
        @(posedge clk);
        #1;
        issue_valid = iv; issue_op = op; issue_rd = rd;
        fpu_done = dn; fpu_result = res; fpu_exc = ex;
        exc_clr = clr; rst = r;
        @(negedge clk);
    endtask

    task automatic idle();
        drv(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [OPW-1:0] op, input logic [4:0] rd);
        drv(1'b1, op, rd, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic done(input logic [31:0] res, input logic [4:0] ex, input logic clr);
        drv(1'b0, '0, '0, 1'b1, res, ex, clr, 1'b0);
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_rd = '0;
        fpu_done = 1'b0; fpu_result = '0; fpu_exc = '0; exc_clr = 1'b0;
        @(posedge clk);
        #1;
        model_on = 1'b1;
        @(negedge clk);

        // Reset: stall follows issue_valid, nothing captured.
        drv(1'b1, 3'd5, 5'd9, 1'b1, 32'hFFFF_FFFF, 5'b11111, 1'b0, 1'b1);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_we",    32'(fp_we), 32'd0);
        idle();
        check("reset_exc",  32'(exc_sticky),  32'd0);
        check("reset_terr", 32'(timeout_err), 32'd0);
        check("reset_op",   32'(fpu_op),      32'd0);

        // Basic op: issue at cycle 0 (held while stalled), done at cycle 4.
        issue(FP_OP_SUB, 5'd5);                                  // cycle 0
        check("basic_c0_stall", 32'(stall),     32'd1);
        check("basic_c0_start", 32'(fpu_start), 32'd0);
        issue(FP_OP_SUB, 5'd5);                                  // cycle 1
        check("basic_c1_start", 32'(fpu_start), 32'd1);
        check("basic_c1_op",    32'(fpu_op),    32'(FP_OP_SUB));
        issue(FP_OP_SUB, 5'd5);                                  // cycle 2
        check("basic_c2_start", 32'(fpu_start), 32'd0);
        issue(FP_OP_SUB, 5'd5);                                  // cycle 3
        drv(1'b1, FP_OP_SUB, 5'd5, 1'b1, 32'h3F80_0000, 5'b0, 1'b0, 1'b0); // cycle 4
        check("basic_c4_stall", 32'(stall), 32'd1);
        check("basic_c4_we",    32'(fp_we), 32'd0);
        idle();                                                  // cycle 5
        check("basic_c5_we",    32'(fp_we), 32'd1);
        check("basic_c5_wn",    32'(fp_wn), 32'd5);
        check("basic_c5_wd",    fp_wd,      32'h3F80_0000);
        check("basic_c5_stall", 32'(stall), 32'd0);
        idle();
        check("basic_c6_we",    32'(fp_we), 32'd0);

        // Fastest op: done in the first waiting cycle, write 3 cycles after issue.
        issue(FP_OP_MUL, 5'd7);
        idle();
        done(32'h4000_0000, 5'b00010, 1'b0);
        idle();
        check("fast_we", 32'(fp_we), 32'd1);
        check("fast_wn", 32'(fp_wn), 32'd7);
        check("fast_wd", fp_wd,      32'h4000_0000);
        idle();
        check("exc_first", 32'(exc_sticky), 32'b00010);

        // Exceptions accumulate, then a clear coinciding with done keeps new flags only.
        issue(FP_OP_DIV, 5'd1);
        idle();
        idle();
        done(32'h0000_0001, 5'b01000, 1'b0);
        idle();
        idle();
        check("exc_accum", 32'(exc_sticky), 32'b01010);
        issue(FP_OP_SQRT, 5'd2);
        idle();
        done(32'h0000_0002, 5'b00001, 1'b1);
        idle();
        idle();
        check("exc_clr_done", 32'(exc_sticky), 32'b00001);

        // Stray done while idle is ignored.
        done(32'hDEAD_BEEF, 5'b11111, 1'b0);
        check("stray_stall", 32'(stall), 32'd0);
        idle();
        check("stray_exc", 32'(exc_sticky), 32'b00001);
        check("stray_we",  32'(fp_we),      32'd0);

        // Timeout after 16 waiting cycles with no done.
        issue(FP_OP_CVT, 5'd3);
        idle();
        for (int i = 0; i < TIMEOUT; i++) begin
            idle();
            check("to_wait_stall", 32'(stall), 32'd1);
        end
        idle();
        check("to_stall", 32'(stall),       32'd0);
        check("to_terr",  32'(timeout_err), 32'd1);
        check("to_we",    32'(fp_we),       32'd0);

        // Next issue clears timeout_err at LAUNCH; done in the 16th waiting cycle wins.
        issue(FP_OP_MIN, 5'd4);
        check("to_terr_held", 32'(timeout_err), 32'd1);
        idle();
        check("to_terr_launch", 32'(timeout_err), 32'd0);
        check("to_start",       32'(fpu_start),   32'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) idle();
        done(32'hCAFE_F00D, 5'b0, 1'b0);
        idle();
        check("edge_we",   32'(fp_we),       32'd1);
        check("edge_wd",   fp_wd,            32'hCAFE_F00D);
        check("edge_terr", 32'(timeout_err), 32'd0);
        idle();

        // Reset in WAIT, done one cycle later: operation abandoned.
        issue(FP_OP_MAX, 5'd9);
        idle();
        idle();
        drv(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("mid_rst_start", 32'(fpu_start), 32'd0);
        check("mid_rst_stall", 32'(stall),     32'd0);
        done(32'h1234_5678, 5'b11111, 1'b0);
        check("mid_we",    32'(fp_we),       32'd0);
        check("mid_stall", 32'(stall),       32'd0);
        check("mid_op",    32'(fpu_op),      32'd0);
        check("mid_exc",   32'(exc_sticky),  32'd0);
        check("mid_terr",  32'(timeout_err), 32'd0);
        idle();
        check("mid_we2",   32'(fp_we),       32'd0);
        idle();

        model_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT cycles before the operation is aborted.
REQ-002 Parameter OPW, default 3: width of the FP opcode.
REQ-003 Ports, as name / direction / width / meaning:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  decoded instruction is an FP op.
- issue_op  in  OPW  FP opcode.
- issue_rd  in  5  FP destination register.
- stall  out  1  core holds PC and register writes.
- fpu_start  out  1  one-cycle launch pulse to the FPU.
- fpu_op  out  OPW  opcode to the FPU, held stable from launch until done.
- fpu_done  in  1  FPU result valid (one-cycle pulse).
- fpu_result  in  32  FPU result.
- fpu_exc  in  5  FPU exception flags, valid with fpu_done.
- fp_we  out  1  FP register-file write enable.
- fp_wn  out  5  FP write register number.
- fp_wd  out  32  FP write data.
- exc_sticky  out  5  accumulated exception flags.
- exc_clr  in  1  clear exc_sticky.
- timeout_err  out  1  sticky: the last operation timed out.

Function
REQ-004 The FSM SHALL have four states: IDLE, LAUNCH, WAIT and WB.
REQ-005 In IDLE with issue_valid=1, the block SHALL capture issue_op and issue_rd, then go to LAUNCH.
REQ-006 In LAUNCH, fpu_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-007 In WAIT, fpu_done=1 SHALL capture fpu_result into a 32-bit register and go to WB.
REQ-008 fpu_done SHALL be ignored in every state other than WAIT.
REQ-009 In WB, fp_we SHALL be 1 for exactly one cycle, with fp_wn equal to the captured rd and fp_wd equal to the captured result; the FSM then SHALL return to IDLE.
REQ-010 stall SHALL be combinational, equal to (IDLE and issue_valid) or LAUNCH or WAIT.
REQ-011 stall SHALL be 0 in WB, so the PC advances on the same edge as the register write.
REQ-012 Issue-to-writeback latency SHALL be 2 + N cycles, where N is the number of WAIT cycles until fpu_done (N>=1).
REQ-013 A WAIT counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-014 If the WAIT counter reaches TIMEOUT without fpu_done, the FSM SHALL go to IDLE with no write, set timeout_err, and deassert stall.
REQ-015 If fpu_done arrives in the same cycle the counter reaches TIMEOUT, fpu_done SHALL win: go to WB, no timeout.
REQ-016 On each accepted fpu_done, exc_sticky SHALL be updated to exc_sticky OR fpu_exc.
REQ-017 exc_clr SHALL zero exc_sticky; if exc_clr coincides with an accepted fpu_done, the result SHALL be fpu_exc only.
REQ-018 timeout_err SHALL clear when the next operation is launched (LAUNCH state).
REQ-019 fpu_op SHALL be driven from the captured opcode register, never directly from issue_op.
REQ-020 issue_valid SHALL be ignored outside IDLE; the core guarantees the instruction is held while stall=1.

Reset
REQ-021 While rst=1 at posedge clk, the FSM SHALL go to IDLE and the WAIT counter, captured op/rd/result, exc_sticky and timeout_err SHALL all go to 0.
REQ-022 Reset SHALL take priority over every other input, including fpu_done and exc_clr.
REQ-023 Reset asserted mid-operation (LAUNCH, WAIT or WB) SHALL abandon the operation with no fp_we pulse.
REQ-024 During reset, fpu_start and fp_we SHALL be 0; stall SHALL follow REQ-010 with state IDLE.

Structure
REQ-025 The state enum, the opcode width and the FP opcode constants SHALL live in the shared package fpu_pkg.
REQ-026 The WAIT counter SHALL be one sub-module, fpu_timeout_ctr (clear, enable, count >= TIMEOUT output).
REQ-027 The counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-028 Basic op: issue_valid=1, op=3'b001, rd=5 at cycle 0, fpu_done at cycle 4 with result 0x3F800000 -> fpu_start at cycle 1, stall high cycles 0-4, fp_we at cycle 5 with fp_wn=5 and fp_wd=0x3F800000.
REQ-029 Fastest op: fpu_done in the first WAIT cycle -> fp_we exactly 3 cycles after issue.
REQ-030 Timeout: no fpu_done for 16 WAIT cycles -> timeout_err=1, no fp_we, stall drops; the next issue clears timeout_err at LAUNCH.
REQ-031 Exceptions: fpu_exc=5'b00010, then an op with 5'b01000 -> exc_sticky=5'b01010; exc_clr coincident with fpu_exc=5'b00001 -> exc_sticky=5'b00001.
REQ-032 Reset mid-operation: rst pulsed in WAIT, then fpu_done one cycle later -> no fp_we, FSM in IDLE, all outputs at their reset values.
REQ-033 Stray done: fpu_done pulsed while in IDLE -> no state change, exc_sticky unchanged.
